mem_bus_unit: RTL
=================

Name: mem_bus_unit

Overview:
- Parametrised memory-side front end for the multi-cycle CPU. Owns the program counter, instruction register and data-address path.
- Arbitrates instruction fetch against data load/store onto a single memory port.
- Adds a wait-state handshake (mem_ready), branch-target PC loading and a bus-timeout error.
- Sits between the control FSM/datapath and RAM.

Parameters:
DATA_W, 16, memory word and instruction width
ADDR_W, 9, memory address width; PC width
RESET_VECTOR, 0, PC value after reset (ADDR_W bits)
MAX_WAIT, 15, wait cycles tolerated before abort; 0 disables timeout

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
fetch_req  in  1  request instruction fetch at pc (or pc_target if pc_load same cycle)
data_req  in  1  request data access
data_we  in  1  1 = store, 0 = load; sampled with data_req
data_addr  in  ADDR_W  data access address
data_wdata  in  DATA_W  store data
pc_load  in  1  load pc from pc_target
pc_target  in  ADDR_W  branch/jump target
read_data  in  DATA_W  RAM read data
mem_ready  in  1  RAM completes current command this cycle
mem_cmd  out  2  NONE/READ/WRITE
mem_addr  out  ADDR_W  RAM address
write_data  out  DATA_W  RAM write data
instruction  out  DATA_W  instruction register
pc  out  ADDR_W  program counter
rdata  out  DATA_W  last load result
busy  out  1  access in progress
done  out  1  one-cycle completion pulse
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE, pc=RESET_VECTOR, instruction=0, rdata=0, write_data=0, mem_cmd=NONE, mem_addr=RESET_VECTOR, busy=0, done=0, bus_err=0, wait count=0. Reset mid-access aborts it: mem_cmd=NONE on the next cycle and no done pulse.
- States: IDLE, FETCH, LOAD, STORE. busy=1 exactly when state != IDLE. All outputs are registered.
- IDLE, mem_cmd=NONE, mem_addr=pc. Requests are sampled only in IDLE and ignored while busy.
- IDLE request priority is data_req > fetch_req.
- pc_load alone: pc<=pc_target next cycle; no memory access and no done pulse.
- pc_load with fetch_req (and data_req=0): fetch address=pc_target.
- pc_load with data_req: pc<=pc_target; data access proceeds and any fetch_req is dropped.
- Accept in cycle N: state, mem_cmd and mem_addr are valid from N+1. Store data is latched into write_data at N+1.
- FETCH/LOAD drive mem_cmd=READ; STORE drives mem_cmd=WRITE. mem_addr and write_data are held stable until completion.
- Completion is the first cycle K>=N+1 with mem_ready=1. At K+1:
  - state=IDLE, mem_cmd=NONE, done=1 for one cycle.
  - FETCH: instruction<=read_data(K), pc<=fetch_addr+1, wrapping mod 2^ADDR_W (all-ones -> 0).
  - LOAD: rdata<=read_data(K).
  - STORE: nothing captured.
- Minimum latency is request to done = 2 cycles. A new request may be issued in the cycle done=1.
- Timeout:
  - The counter increments on each access cycle with mem_ready=0.
  - When it reaches MAX_WAIT (MAX_WAIT>0) while mem_ready stays 0, the access aborts: next cycle is IDLE, mem_cmd=NONE, done=1, bus_err<=1.
  - On abort, pc/instruction/rdata are unchanged.
  - mem_ready=1 in the same cycle the count would expire counts as normal completion.
  - bus_err is cleared only by reset. The counter clears on each accept.

Decomposition:
- Package mem_bus_pkg holds:
  - mem_cmd constants MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10;
  - state encoding IDLE/FETCH/LOAD/STORE;
  - width localparam for the wait counter, $clog2(MAX_WAIT+1).
- One sub-module, bus_wait_timer: a clear/enable counter with an expire output at MAX_WAIT, disabled when MAX_WAIT=0.

Test Plan:
- Reset, then fetch_req with mem_ready tied 1 and read_data=16'hD105 -> mem_cmd=READ, mem_addr=0 at N+1; done at N+2; instruction=16'hD105; pc=1.
- Store with data_addr=9'h1F0, data_wdata=16'hBEEF, mem_ready low 3 cycles -> mem_cmd=WRITE, mem_addr=1F0 and write_data=BEEF held 4 cycles; done one cycle after mem_ready; pc unchanged.
- fetch_req+pc_load with pc_target=9'h1FF -> fetch from 1FF; pc wraps to 0 after done. pc_load alone with target 9'h040 -> pc=040, no done pulse.
- fetch_req and data_req (load, addr 9'h020, read_data=16'h1234) same cycle -> LOAD first, rdata=1234; fetch not performed; instruction unchanged.
- MAX_WAIT=4, mem_ready held 0 -> abort after 4 wait cycles; done=1, bus_err=1 stays set through later successful fetches until reset.
- Reset asserted mid-FETCH with mem_ready=0 -> next cycle mem_cmd=NONE, pc=RESET_VECTOR, busy=0, no done.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared definitions for the memory-side front end of the multi-cycle CPU:
// memory command encodings, access FSM states and the sizing rule for the
// wait-state counter.
package mem_bus_pkg;

  // Command presented to RAM on mem_cmd
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Access FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    LOAD  = 2'b10,
    STORE = 2'b11
  } bus_state_t;

  // Width needed to count 0..max_wait. A zero-width vector is not legal,
  // so a disabled timeout (max_wait = 0) still gets a one-bit counter.
  function automatic int wait_cnt_w(input int max_wait);
    if (max_wait < 1) begin
      return 1;
    end
    return $clog2(max_wait + 1);
  endfunction

  // Counter width for the default timeout of 15 wait cycles
  localparam int WAIT_CNT_W = wait_cnt_w(15);

endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer
// Counts wait-state cycles of a memory access and flags when the access has
// waited too long.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, clears the count
//   clear   : restart the count (asserted when a new access is accepted)
//   enable  : one more wait cycle is being spent this cycle
//   expire  : this enabled cycle brings the count to MAX_WAIT; the owner
//             aborts the access on the following edge
// With MAX_WAIT = 0 the timer is disabled and expire is tied low.
module bus_wait_timer
  import mem_bus_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = wait_cnt_w(MAX_WAIT);

  logic [CNT_W-1:0] count_reg;

  generate
    if (MAX_WAIT > 0) begin : g_timer
      localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count_reg <= '0;
        end else if (enable && (count_reg != CNT_MAX)) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end

      // Expiry is flagged on the wait cycle that would make the count reach
      // MAX_WAIT, so the abort lands exactly MAX_WAIT wait cycles in.
      assign expire = enable && (count_reg == LAST);
    end else begin : g_off
      logic unused_inputs;
      assign count_reg     = '0;
      assign expire        = 1'b0;
      assign unused_inputs = ^{clk, reset, clear, enable, count_reg};
    end
  endgenerate

endmodule

// File: rtl/mem_bus_unit.sv
// mem_bus_unit
// Memory-side front end of the multi-cycle CPU. Owns the program counter,
// instruction register and data-address path, and arbitrates instruction
// fetch against data load/store on a single RAM port with a wait-state
// handshake and a bus timeout.
//   clk, reset          : clock, synchronous active-high reset
//   fetch_req           : fetch instruction at pc (pc_target if pc_load)
//   data_req, data_we   : data access request, 1 = store / 0 = load
//   data_addr,data_wdata: data access address and store data
//   pc_load, pc_target  : branch/jump PC load
//   read_data, mem_ready: RAM read data and completion handshake
//   mem_cmd, mem_addr, write_data : RAM command, address, store data
//   instruction, pc, rdata        : instruction register, PC, load result
//   busy, done, bus_err           : access in progress, completion pulse,
//                                   sticky timeout flag
// Every output comes straight from a register.
module mem_bus_unit
  import mem_bus_pkg::*;
#(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 9,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                MAX_WAIT     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              bus_err
);

  bus_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] instruction_reg, instruction_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [DATA_W-1:0] write_data_reg, write_data_next;
  logic [1:0]        mem_cmd_reg, mem_cmd_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              bus_err_reg, bus_err_next;

  logic accept;
  logic wait_cycle;
  logic wait_expire;

  // A wait cycle is any cycle spent in an access without the RAM finishing
  assign wait_cycle = (state_reg != IDLE) && !mem_ready;

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (wait_cycle),
    .expire (wait_expire)
  );

  // State register and all output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_VECTOR;
      instruction_reg <= '0;
      rdata_reg       <= '0;
      write_data_reg  <= '0;
      mem_cmd_reg     <= MEM_NONE;
      mem_addr_reg    <= RESET_VECTOR;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      bus_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instruction_reg <= instruction_next;
      rdata_reg       <= rdata_next;
      write_data_reg  <= write_data_next;
      mem_cmd_reg     <= mem_cmd_next;
      mem_addr_reg    <= mem_addr_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      bus_err_reg     <= bus_err_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instruction_next = instruction_reg;
    rdata_next       = rdata_reg;
    write_data_next  = write_data_reg;
    mem_cmd_next     = mem_cmd_reg;
    mem_addr_next    = mem_addr_reg;
    done_next        = 1'b0;
    bus_err_next     = bus_err_reg;
    accept           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (data_req) begin
          // Data wins; a concurrent fetch_req is dropped, pc_load still lands
          accept        = 1'b1;
          mem_addr_next = data_addr;
          if (pc_load) begin
            pc_next = pc_target;
          end
          if (data_we) begin
            state_next      = STORE;
            mem_cmd_next    = MEM_WRITE;
            write_data_next = data_wdata;
          end else begin
            state_next   = LOAD;
            mem_cmd_next = MEM_READ;
          end
        end else if (fetch_req) begin
          accept        = 1'b1;
          state_next    = FETCH;
          mem_cmd_next  = MEM_READ;
          mem_addr_next = pc_load ? pc_target : pc_reg;
          if (pc_load) begin
            pc_next = pc_target;
          end
        end else if (pc_load) begin
          // Idle address tracks the PC so it follows the branch immediately
          pc_next       = pc_target;
          mem_addr_next = pc_target;
        end else begin
          mem_addr_next = pc_reg;
        end
      end

      FETCH, LOAD, STORE: begin
        if (mem_ready) begin
          state_next    = IDLE;
          mem_cmd_next  = MEM_NONE;
          done_next     = 1'b1;
          mem_addr_next = pc_reg;
          if (state_reg == FETCH) begin
            // mem_addr still holds the fetch address; +1 wraps naturally
            instruction_next = read_data;
            pc_next          = mem_addr_reg + ADDR_W'(1);
            mem_addr_next    = mem_addr_reg + ADDR_W'(1);
          end else if (state_reg == LOAD) begin
            rdata_next = read_data;
          end
        end else if (wait_expire) begin
          // Abort: finish the handshake but leave architectural state alone
          state_next    = IDLE;
          mem_cmd_next  = MEM_NONE;
          done_next     = 1'b1;
          bus_err_next  = 1'b1;
          mem_addr_next = pc_reg;
        end
      end

      default: begin
        state_next   = IDLE;
        mem_cmd_next = MEM_NONE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign mem_cmd     = mem_cmd_reg;
  assign mem_addr    = mem_addr_reg;
  assign write_data  = write_data_reg;
  assign instruction = instruction_reg;
  assign pc          = pc_reg;
  assign rdata       = rdata_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign bus_err     = bus_err_reg;

endmodule
